twiddle_seq: RTL and testbench
==============================

TWIDDLE_SEQ -- requirements
Module: twiddle_seq

Interface
REQ-001 SHALL have parameter WORD_LEN, default 11: twiddle word width, two's complement Q1.(WORD_LEN-1).
REQ-002 SHALL have parameter LOG2N, default 5, legal range 3..10: FFT size N = 2^LOG2N.
REQ-003 SHALL have port i_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: synchronous active-high reset.
REQ-005 SHALL have port i_start, input, 1: request one stage sequence.
REQ-006 SHALL have port i_stage, input, 4: radix-2 DIF stage index s.
REQ-007 SHALL have port i_inv, input, 1: 1 = inverse FFT, output is the conjugate twiddle.
REQ-008 SHALL have port i_ready, input, 1: downstream accepts the current output.
REQ-009 SHALL have port o_busy, output, 1: sequence in progress.
REQ-010 SHALL have port o_err, output, 1: one-cycle pulse when a start request carries an illegal stage.
REQ-011 SHALL have port o_valid, output, 1: o_re, o_im, o_k and o_last are valid.
REQ-012 SHALL have port o_last, output, 1: marks the final twiddle of the sequence.
REQ-013 SHALL have port o_k, output, LOG2N-1: twiddle exponent k.
REQ-014 SHALL have port o_re, output, WORD_LEN: signed real part.
REQ-015 SHALL have port o_im, output, WORD_LEN: signed imaginary part.

Function
REQ-016 SHALL hold a quarter-wave table C[m], m = 0..N/4, computed at elaboration.
- C[m] = round(cos(2*pi*m/N) * 2^(WORD_LEN-1)).
- Clamp to 2^(WORD_LEN-1)-1.
- No runtime-writable storage.
REQ-017 SHALL map exponent k (0..N/2-1) to the forward twiddle W^k = cos - j*sin:
- k <= N/4: re = C[k], im = -C[N/4-k].
- k > N/4: re = -C[N/2-k], im = -C[k-N/4].
REQ-018 SHALL, when i_inv is latched 1, output im with its sign inverted (+C instead of -C). re is unchanged.
REQ-019 SHALL produce every negation as an exact two's complement negation of a clamped value, which never overflows.
REQ-020 SHALL use a state machine with states IDLE and RUN.
- IDLE -> RUN: i_start=1 and i_stage < LOG2N at a rising edge. i_stage and i_inv are latched on that edge.
- i_start=1 with i_stage >= LOG2N in IDLE: o_err=1 for the next cycle only, state stays IDLE.
REQ-021 SHALL ignore i_start entirely in RUN, including during the cycle of the last handshake.
REQ-022 SHALL step butterfly counter b from 0 to N/2-1, one step per issued entry.
- Exponent k = (b mod (N / 2^(s+1))) * 2^s.
- o_last = 1 exactly when b = N/2-1.
REQ-023 SHALL use a two-stage pipeline (exponent/address register, then table-read/sign register).
- o_busy = 1 from the edge after start acceptance.
- First o_valid = 1 two cycles after the acceptance edge.
REQ-024 SHALL hand over data on the valid/ready handshake:
- Transfer occurs when o_valid=1 and i_ready=1.
- While o_valid=1 and i_ready=0, the whole pipeline stalls and all outputs hold stable.
- o_valid never drops without a transfer.
- With i_ready held 1, throughput is one twiddle per cycle.
REQ-025 SHALL clear o_busy and o_valid and return to IDLE on the edge where the o_last entry transfers.
REQ-026 SHALL issue exactly N/2 transfers per sequence, with no duplicates and no gaps.

Reset
REQ-027 SHALL, when i_rst=1 at a rising edge, enter IDLE and clear every output: o_busy, o_valid, o_last, o_err, o_k, o_re, o_im all 0.
REQ-028 SHALL let reset abandon any sequence in progress, including mid-stall; no further output of that sequence is produced.
REQ-029 SHALL give i_rst priority over i_start in the same cycle.

Verification (defaults: WORD_LEN=11, LOG2N=5)
REQ-030 SHALL cover forward stage 0 with i_ready=1:
- o_valid rises two cycles after start; 16 transfers with k = 0..15.
- k=0: (1023, 0). k=1: (1004, -200). k=8: (0, -1023). k=15: (-1004, -200).
- o_last only on the 16th transfer; o_busy low the cycle after.
REQ-031 SHALL cover stage 2: k sequence 0,4,8,12 repeated 4 times; k=4 gives (724, -724), k=12 gives (-724, -724). Stage 4: all 16 transfers k=0, (1023, 0).
REQ-032 SHALL cover backpressure:
- Drop i_ready for 3 cycles at transfer 5: outputs frozen during the stall.
- The sequence resumes at transfer 5; total transfers still 16.
REQ-033 SHALL cover inverse mode: stage 0 with i_inv=1 gives k=1 (1004, +200) and k=8 (0, +1023).
REQ-034 SHALL cover illegal and ignored starts:
- i_stage=5 in IDLE: o_err pulses one cycle, o_busy stays 0.
- i_start during RUN: no effect on the sequence.
REQ-035 SHALL cover reset mid-run: assert i_rst at transfer 7, then o_valid=0, o_busy=0 next cycle; a fresh start then begins again at k=0.

Source files
------------

// File: rtl/twiddle_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_seq_if
//  Description : Control/handshake bundle for twiddle_seq. The master side
//                issues start requests and accepts twiddles. The slave side
//                is the sequencer.
//                  i_start/i_stage/i_inv : stage sequence request
//                  i_ready               : downstream accepts current output
//                  o_busy/o_err          : sequencer status
//                  o_valid/o_last/o_k/o_re/o_im : twiddle output stream
//  Revision    : 1.0 - initial release
// ============================================================================
interface twiddle_seq_if #(
    parameter int WORD_LEN = 11,
    parameter int LOG2N    = 5
);
    logic                       i_start;
    logic [3:0]                 i_stage;
    logic                       i_inv;
    logic                       i_ready;
    logic                       o_busy;
    logic                       o_err;
    logic                       o_valid;
    logic                       o_last;
    logic [LOG2N-2:0]           o_k;
    logic signed [WORD_LEN-1:0] o_re;
    logic signed [WORD_LEN-1:0] o_im;

    modport master (
        output i_start, i_stage, i_inv, i_ready,
        input  o_busy, o_err, o_valid, o_last, o_k, o_re, o_im
    );

    modport slave (
        input  i_start, i_stage, i_inv, i_ready,
        output o_busy, o_err, o_valid, o_last, o_k, o_re, o_im
    );
endinterface
`default_nettype wire

// File: rtl/twiddle_seq.sv
`default_nettype none
// ============================================================================
//  Module      : twiddle_seq
//  Description : Radix-2 DIF twiddle-factor sequencer. On an accepted start it
//                streams the N/2 twiddles W^k of one stage (conjugated when
//                i_inv is set) over a valid/ready handshake, using a
//                quarter-wave cosine table and a two-stage pipeline.
//  Ports       : i_clk - clock, i_rst - synchronous active-high reset,
//                bus   - twiddle_seq_if.slave (start request, status, stream)
//  Revision    : 1.0 - initial release
// ============================================================================
module twiddle_seq #(
    parameter int WORD_LEN = 11,
    parameter int LOG2N    = 5
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst,
    twiddle_seq_if.slave     bus
);
    localparam int c_n  = 1 << LOG2N;
    localparam int c_bw = LOG2N - 1;              // width of b and k
    localparam int c_q  = 1 << (LOG2N - 2);       // N/4
    localparam real c_pi = 3.14159265358979323846;
    localparam logic [c_bw-1:0] c_b_max = '1;
    localparam logic [c_bw-1:0] c_q_idx = c_bw'(c_q);

    // Quantised cosine, rounded half-up and clamped to the largest positive
    // code so every table entry can be negated without overflow.
    function automatic logic signed [WORD_LEN-1:0] cos_q(input int m);
        real v;
        int  r;
        v = $cos(2.0 * c_pi * real'(m) / real'(c_n)) * (2.0 ** (WORD_LEN - 1));
        r = $rtoi(v + 0.5);
        if (r > (1 << (WORD_LEN - 1)) - 1) r = (1 << (WORD_LEN - 1)) - 1;
        return WORD_LEN'(r);
    endfunction

    logic signed [WORD_LEN-1:0] w_cos [0:c_q];

    for (genvar m = 0; m <= c_q; m++) begin : g_table
        assign w_cos[m] = cos_q(m);
    end

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;
    state_t r_state, w_state_nxt;

    logic                       r_err, r_inv, r_issuing;
    logic [3:0]                 r_stage;
    logic [c_bw-1:0]            r_b;
    logic                       r_s1_valid, r_s1_last;
    logic [c_bw-1:0]            r_s1_k;
    logic                       r_valid, r_last;
    logic [c_bw-1:0]            r_k;
    logic signed [WORD_LEN-1:0] r_re, r_im;

    logic                       w_accept, w_err_req, w_stage_ok;
    logic                       w_adv, w_issue, w_last_xfer;
    logic [c_bw-1:0]            w_k, w_idx_re, w_idx_im;
    logic                       w_hi;
    logic signed [WORD_LEN-1:0] w_re, w_im, w_im_mag;

    assign w_stage_ok  = (bus.i_stage < 4'(LOG2N));
    // The whole pipeline advances unless the output is held by backpressure.
    assign w_adv       = !r_valid || bus.i_ready;
    assign w_issue     = r_issuing && w_adv;
    assign w_last_xfer = r_valid && bus.i_ready && r_last;
    // (b mod 2^(c_bw-s)) * 2^s is exactly b << s truncated to c_bw bits.
    assign w_k         = r_b << r_stage;

    // Fold k onto the quarter-wave table. N/2-k is taken modulo 2^c_bw.
    assign w_hi     = (r_s1_k > c_q_idx);
    assign w_idx_re = w_hi ? (c_bw'(0) - r_s1_k) : r_s1_k;
    assign w_idx_im = w_hi ? (r_s1_k - c_q_idx) : (c_q_idx - r_s1_k);
    assign w_re     = w_hi ? -w_cos[w_idx_re] : w_cos[w_idx_re];
    assign w_im_mag = w_cos[w_idx_im];
    assign w_im     = r_inv ? w_im_mag : -w_im_mag;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_err_req   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    if (w_stage_ok) begin
                        w_accept    = 1'b1;
                        w_state_nxt = RUN;
                    end else begin
                        w_err_req   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (w_last_xfer) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err      <= 1'b0;
            r_inv      <= 1'b0;
            r_stage    <= '0;
            r_issuing  <= 1'b0;
            r_b        <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_k     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_k        <= '0;
            r_re       <= '0;
            r_im       <= '0;
        end else begin
            r_err <= w_err_req;
            if (w_accept) begin
                r_stage   <= bus.i_stage;
                r_inv     <= bus.i_inv;
                r_b       <= '0;
                r_issuing <= 1'b1;
            end else if (w_issue) begin
                r_b <= r_b + 1'b1;
                if (r_b == c_b_max) r_issuing <= 1'b0;
            end
            if (w_adv) begin
                // Stage 1: exponent register
                r_s1_valid <= w_issue;
                if (w_issue) begin
                    r_s1_k    <= w_k;
                    r_s1_last <= (r_b == c_b_max);
                end
                // Stage 2: table read and sign
                r_valid <= r_s1_valid;
                r_last  <= r_s1_valid && r_s1_last;
                if (r_s1_valid) begin
                    r_k  <= r_s1_k;
                    r_re <= w_re;
                    r_im <= w_im;
                end
            end
        end
    end

    assign bus.o_busy  = (r_state == RUN);
    assign bus.o_err   = r_err;
    assign bus.o_valid = r_valid;
    assign bus.o_last  = r_last;
    assign bus.o_k     = r_k;
    assign bus.o_re    = r_re;
    assign bus.o_im    = r_im;
endmodule
`default_nettype wire

// File: tb/tb_twiddle_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_twiddle_seq
//  Description : Self-checking bench for twiddle_seq (WORD_LEN=11, LOG2N=5).
//                Expected twiddles come from direct cos/sin of 2*pi*k/N.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_twiddle_seq;
    localparam int  WORD_LEN = 11;
    localparam int  LOG2N    = 5;
    localparam int  N        = 1 << LOG2N;
    localparam int  HALF     = N / 2;
    localparam int  MAXV     = (1 << (WORD_LEN - 1)) - 1;
    localparam int  SNAPW    = 2 + (LOG2N - 1) + 2 * WORD_LEN;
    localparam real PI       = 3.14159265358979323846;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    twiddle_seq_if #(.WORD_LEN(WORD_LEN), .LOG2N(LOG2N)) bus ();

    twiddle_seq #(.WORD_LEN(WORD_LEN), .LOG2N(LOG2N)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int got_k  [HALF];
    int got_re [HALF];
    int got_im [HALF];

    // Round |v| * 2^(WORD_LEN-1) half-up, clamp, restore sign.
    function automatic int qval(real v);
        real a;
        int  m;
        a = (v < 0.0) ? -v : v;
        m = $rtoi(a * (2.0 ** (WORD_LEN - 1)) + 0.5);
        if (m > MAXV) m = MAXV;
        return (v < 0.0) ? -m : m;
    endfunction

    function automatic int model_re(int k);
        return qval($cos(2.0 * PI * real'(k) / real'(N)));
    endfunction

    function automatic int model_im(int k, bit inv);
        int s;
        s = qval($sin(2.0 * PI * real'(k) / real'(N)));
        return inv ? s : -s;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Runs one full sequence; stall_at/stall_len force a backpressure window,
    // rand_ready randomises i_ready, poke holds i_start high during the run.
    task automatic run_seq(input int stage, input bit inv, input int stall_at,
                           input int stall_len, input bit rand_ready, input bit poke);
        int   exp_k[$];
        int   idx, cyc, stall_left;
        bit   stall_done, stalled_prev, rdy;
        logic [SNAPW-1:0] snap;
        for (int b = 0; b < HALF; b++)
            exp_k.push_back((b % (N >> (stage + 1))) << stage);
        bus.i_start = 1'b1;
        bus.i_stage = 4'(stage);
        bus.i_inv   = inv;
        bus.i_ready = 1'b1;
        step();
        bus.i_start = poke;
        bus.i_stage = 4'd0;
        bus.i_inv   = ~inv;
        n_vec++;
        if (bus.o_busy !== 1'b1 || bus.o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL accept_state: busy=%b valid=%b, required busy=1 valid=0", bus.o_busy, bus.o_valid);
        end
        step();
        n_vec++;
        if (bus.o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: valid=%b one cycle after start, required 0", bus.o_valid);
        end
        step();
        n_vec++;
        if (bus.o_valid !== 1'b1) begin
            n_err++;
            $display("FAIL latency: valid=%b two cycles after start, required 1", bus.o_valid);
        end
        idx = 0; cyc = 0; stall_left = 0; stall_done = 0; stalled_prev = 0; snap = '0;
        while (idx < HALF && cyc < 400) begin
            n_vec++;
            if (bus.o_valid !== 1'b1) begin
                n_err++;
                $display("FAIL valid_hold: valid=%b before transfer %0d, required 1", bus.o_valid, idx);
            end
            if (stalled_prev) begin
                n_vec++;
                if ({bus.o_valid, bus.o_last, bus.o_k, bus.o_re, bus.o_im} !== snap) begin
                    n_err++;
                    $display("FAIL stall_freeze: outputs %h, required %h", {bus.o_valid, bus.o_last, bus.o_k, bus.o_re, bus.o_im}, snap);
                end
            end
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else if (idx == stall_at && stall_len > 0 && !stall_done) begin
                rdy = 1'b0;
                stall_left = stall_len - 1;
                stall_done = 1'b1;
            end else begin
                rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            bus.i_ready = rdy;
            if (bus.o_valid === 1'b1 && rdy) begin
                n_vec++;
                if (int'(bus.o_k) !== exp_k[idx] || int'(bus.o_re) !== model_re(exp_k[idx]) ||
                    int'(bus.o_im) !== model_im(exp_k[idx], inv) || bus.o_last !== (idx == HALF - 1)) begin
                    n_err++;
                    $display("FAIL xfer[%0d]: k=%0d re=%0d im=%0d last=%b, required k=%0d re=%0d im=%0d last=%0d",
                             idx, bus.o_k, bus.o_re, bus.o_im, bus.o_last, exp_k[idx],
                             model_re(exp_k[idx]), model_im(exp_k[idx], inv), (idx == HALF - 1));
                end
                got_k[idx]  = int'(bus.o_k);
                got_re[idx] = int'(bus.o_re);
                got_im[idx] = int'(bus.o_im);
                idx++;
            end
            stalled_prev = (bus.o_valid === 1'b1) && !rdy;
            snap = {bus.o_valid, bus.o_last, bus.o_k, bus.o_re, bus.o_im};
            step();
            cyc++;
        end
        bus.i_start = 1'b0;
        bus.i_ready = 1'b1;
        n_vec++;
        if (idx != HALF) begin
            n_err++;
            $display("FAIL xfer_count: %0d transfers within budget, required %0d", idx, HALF);
        end
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL end_state: valid=%b busy=%b after last, required 0 0", bus.o_valid, bus.o_busy);
        end
        step();
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after: valid=%b busy=%b, required 0 0", bus.o_valid, bus.o_busy);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        bus.i_start = 1'b0; bus.i_stage = 4'd0; bus.i_inv = 1'b0; bus.i_ready = 1'b1;
        step(); step();
        n_vec++;
        if ({bus.o_busy, bus.o_valid, bus.o_last, bus.o_err} !== 4'b0000 ||
            bus.o_k !== '0 || bus.o_re !== '0 || bus.o_im !== '0) begin
            n_err++;
            $display("FAIL reset: busy=%b valid=%b last=%b err=%b k=%0d re=%0d im=%0d, required all 0",
                     bus.o_busy, bus.o_valid, bus.o_last, bus.o_err, bus.o_k, bus.o_re, bus.o_im);
        end
        i_rst = 1'b0;
        step();
    endtask

    task automatic test_stage0();
        int exp_tab [8] = '{1023, 0, 1004, -200, 0, -1023, -1004, -200};
        int kk [4] = '{0, 1, 8, 15};
        run_seq(0, 1'b0, -1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (got_re[kk[i]] !== exp_tab[2*i] || got_im[kk[i]] !== exp_tab[2*i+1]) begin
                n_err++;
                $display("FAIL stage0_k%0d: got (%0d,%0d), required (%0d,%0d)", kk[i],
                         got_re[kk[i]], got_im[kk[i]], exp_tab[2*i], exp_tab[2*i+1]);
            end
        end
    endtask

    task automatic test_stage2_stage4();
        run_seq(2, 1'b0, -1, 0, 1'b0, 1'b0);
        n_vec++;
        if (got_k[5] !== 4 || got_re[5] !== 724 || got_im[5] !== -724 ||
            got_k[7] !== 12 || got_re[7] !== -724 || got_im[7] !== -724) begin
            n_err++;
            $display("FAIL stage2_vals: k4=(%0d,%0d) k12=(%0d,%0d), required (724,-724) (-724,-724)",
                     got_re[5], got_im[5], got_re[7], got_im[7]);
        end
        run_seq(4, 1'b0, -1, 0, 1'b0, 1'b0);
        n_vec++;
        if (got_k[15] !== 0 || got_re[15] !== 1023 || got_im[15] !== 0) begin
            n_err++;
            $display("FAIL stage4_vals: k=%0d (%0d,%0d), required k=0 (1023,0)", got_k[15], got_re[15], got_im[15]);
        end
    endtask

    task automatic test_backpressure();
        run_seq(0, 1'b0, 5, 3, 1'b0, 1'b0);
        run_seq(1, 1'b1, 0, 4, 1'b0, 1'b0);
    endtask

    task automatic test_inverse();
        run_seq(0, 1'b1, -1, 0, 1'b0, 1'b0);
        n_vec++;
        if (got_re[1] !== 1004 || got_im[1] !== 200 || got_re[8] !== 0 || got_im[8] !== 1023) begin
            n_err++;
            $display("FAIL inverse_vals: k1=(%0d,%0d) k8=(%0d,%0d), required (1004,200) (0,1023)",
                     got_re[1], got_im[1], got_re[8], got_im[8]);
        end
    endtask

    task automatic test_illegal_start();
        int bad [2] = '{5, 15};
        for (int i = 0; i < 2; i++) begin
            bus.i_start = 1'b1;
            bus.i_stage = 4'(bad[i]);
            step();
            bus.i_start = 1'b0;
            n_vec++;
            if (bus.o_err !== 1'b1 || bus.o_busy !== 1'b0) begin
                n_err++;
                $display("FAIL illegal_err: stage=%0d err=%b busy=%b, required err=1 busy=0", bad[i], bus.o_err, bus.o_busy);
            end
            step();
            n_vec++;
            if (bus.o_err !== 1'b0 || bus.o_busy !== 1'b0) begin
                n_err++;
                $display("FAIL illegal_pulse: err=%b busy=%b, required 0 0", bus.o_err, bus.o_busy);
            end
        end
        // Reset wins over a simultaneous legal start.
        i_rst = 1'b1;
        bus.i_start = 1'b1;
        bus.i_stage = 4'd0;
        step();
        i_rst = 1'b0;
        bus.i_start = 1'b0;
        step();
        n_vec++;
        if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_priority: busy=%b valid=%b, required 0 0", bus.o_busy, bus.o_valid);
        end
    endtask

    task automatic test_ignored_start();
        run_seq(1, 1'b0, -1, 0, 1'b0, 1'b1);
        run_seq(3, 1'b1, 9, 2, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++)
            run_seq(int'($urandom_range(0, LOG2N - 1)), 1'($urandom_range(0, 1)), -1, 0, 1'b1,
                    1'($urandom_range(0, 1)));
    endtask

    task automatic test_reset_mid_run();
        int xfers, cyc;
        bus.i_start = 1'b1;
        bus.i_stage = 4'd0;
        bus.i_inv   = 1'b0;
        bus.i_ready = 1'b1;
        step();
        bus.i_start = 1'b0;
        xfers = 0; cyc = 0;
        while (xfers < 7 && cyc < 50) begin
            if (bus.o_valid === 1'b1) xfers++;
            step();
            cyc++;
        end
        // Hold the 8th output under backpressure, then reset mid-stall.
        bus.i_ready = 1'b0;
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        bus.i_ready = 1'b1;
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_last !== 1'b0 || xfers != 7) begin
            n_err++;
            $display("FAIL mid_reset: valid=%b busy=%b last=%b xfers=%0d, required 0 0 0 7",
                     bus.o_valid, bus.o_busy, bus.o_last, xfers);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reset_quiet: valid=%b busy=%b, required 0 0", bus.o_valid, bus.o_busy);
            end
        end
        run_seq(0, 1'b0, -1, 0, 1'b0, 1'b0);
        n_vec++;
        if (got_k[0] !== 0 || got_re[0] !== 1023) begin
            n_err++;
            $display("FAIL restart_k0: k=%0d re=%0d, required 0 1023", got_k[0], got_re[0]);
        end
    endtask

    initial begin
        test_reset();
        test_stage0();
        test_stage2_stage4();
        test_backpressure();
        test_inverse();
        test_illegal_start();
        test_ignored_start();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
